// File: rtl/hit_scheduler.sv
// hit_scheduler: walks a ray's triangle list, issues one triangle read per
// cycle, tracks in-flight offsets through a delay line that matches the hit
// datapath latency, and keeps the closest positive-distance hit.
module hit_scheduler #(
  parameter int Q_BITS  = 10,
  parameter int IDX_W   = 16,
  parameter int HIT_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic [IDX_W-1:0] tri_base,
  input  logic [IDX_W-1:0] tri_count,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] mem_addr,
  output logic             tri_valid,
  input  logic             res_valid,
  input  logic             res_hit,
  input  logic [31:0]      res_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic [31:0]      out_t
);

  // One memory-read stage plus the datapath latency; the last stage lines
  // up with res_valid. Distances are compared as raw signed words, so the
  // Q_BITS fraction width does not change any ordering decision.
  localparam int STAGES = 1 + HIT_LAT;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               base_q, base_d;
  logic [IDX_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               iss_q, iss_d;
  logic [IDX_W-1:0]               ret_q, ret_d;
  logic                           best_vld_q, best_vld_d;
  logic [IDX_W-1:0]               best_idx_q, best_idx_d;
  logic signed [31:0]             best_t_q, best_t_d;
  logic [STAGES-1:0]              vld_pipe_q, vld_pipe_d;
  logic [STAGES-1:0][IDX_W-1:0]   off_pipe_q, off_pipe_d;

  logic             busy;
  logic             res_take;
  logic             cand;
  logic             better;
  logic signed [31:0] res_t_s;

  assign res_t_s = res_t;
  assign busy    = (state_q == FETCH) || (state_q == DRAIN);
  // Only results that line up with one of our own issued triangles count,
  // so anything still draining out of the datapath after a reset is dropped.
  assign res_take = res_valid && vld_pipe_q[STAGES-1] && busy;
  assign cand     = res_hit && (res_t_s > 32'sd0);
  // Results return in issue order, so strict less-than keeps the earlier
  // offset on a tie.
  assign better   = !best_vld_q || (res_t_s < best_t_q);

  assign ray_ready = rst_n && (state_q == IDLE);
  assign mem_rd_en = (state_q == FETCH);
  assign mem_addr  = (state_q == FETCH) ? base_q + iss_q : '0;
  assign tri_valid = vld_pipe_q[0];
  assign out_valid = (state_q == DONE);
  assign out_hit   = best_vld_q;
  assign out_idx   = best_idx_q;
  assign out_t     = best_t_q;

  // Next-state, counters, delay line and closest-hit tracking.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    iss_d      = iss_q;
    ret_d      = ret_q;
    best_vld_d = best_vld_q;
    best_idx_d = best_idx_q;
    best_t_d   = best_t_q;
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], mem_rd_en};
    off_pipe_d = {off_pipe_q[STAGES-2:0], iss_q};

    if (res_take) begin
      ret_d = ret_q + 1'b1;
      if (cand && better) begin
        best_vld_d = 1'b1;
        best_idx_d = off_pipe_q[STAGES-1];
        best_t_d   = res_t_s;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (ray_valid) begin
          base_d     = tri_base;
          cnt_d      = tri_count;
          iss_d      = '0;
          ret_d      = '0;
          best_vld_d = 1'b0;
          best_idx_d = '0;
          best_t_d   = '0;
          state_d    = (tri_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        iss_d = iss_q + 1'b1;
        if (iss_d == cnt_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (ret_d == cnt_q) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      iss_q      <= '0;
      ret_q      <= '0;
      best_vld_q <= 1'b0;
      best_idx_q <= '0;
      best_t_q   <= '0;
      vld_pipe_q <= '0;
      off_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      iss_q      <= iss_d;
      ret_q      <= ret_d;
      best_vld_q <= best_vld_d;
      best_idx_q <= best_idx_d;
      best_t_q   <= best_t_d;
      vld_pipe_q <= vld_pipe_d;
      off_pipe_q <= off_pipe_d;
    end
  end

endmodule

// File: tb/tb_hit_scheduler.sv
// Directed bench for hit_scheduler with a behavioural hit datapath model.
module tb_hit_scheduler;
  localparam int IDX_W = 16;
  localparam int HL    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ray_valid;
  logic             ray_ready;
  logic [IDX_W-1:0] tri_base;
  logic [IDX_W-1:0] tri_count;
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_addr;
  logic             tri_valid;
  logic             res_valid;
  logic             res_hit;
  logic [31:0]      res_t;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [IDX_W-1:0] out_idx;
  logic [31:0]      out_t;

  hit_scheduler #(.Q_BITS(10), .IDX_W(IDX_W), .HIT_LAT(HL)) dut (
    .clk(clk), .rst_n(rst_n), .ray_valid(ray_valid), .ray_ready(ray_ready),
    .tri_base(tri_base), .tri_count(tri_count), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .tri_valid(tri_valid), .res_valid(res_valid),
    .res_hit(res_hit), .res_t(res_t), .out_valid(out_valid),
    .out_ready(out_ready), .out_hit(out_hit), .out_idx(out_idx), .out_t(out_t)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result table for the current job, indexed by offset from cur_base.
  logic             tab_h [16];
  logic [31:0]      tab_t [16];
  logic [IDX_W-1:0] cur_base = '0;

  // Datapath model: 1-cycle memory read then HL cycles of hit test.
  logic [HL:0] p_v = '0;
  logic        p_h [HL+1];
  logic [31:0] p_t [HL+1];
  logic [IDX_W-1:0] off_now;
  assign off_now   = mem_addr - cur_base;
  assign res_valid = p_v[HL];
  assign res_hit   = p_h[HL];
  assign res_t     = p_t[HL];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p_v <= {p_v[HL-1:0], mem_rd_en};
    p_h[0] <= (off_now < 16) ? tab_h[off_now[3:0]] : 1'b0;
    p_t[0] <= (off_now < 16) ? tab_t[off_now[3:0]] : 32'h0;
    for (int k = 1; k <= HL; k++) begin
      p_h[k] <= p_h[k-1];
      p_t[k] <= p_t[k-1];
    end
  end

  // Read-address log and tri_valid alignment monitor.
  logic [IDX_W-1:0] addr_q[$];
  int               rd_cyc[$];
  logic             prev_rd = 1'b0;
  logic             mon_en  = 1'b0;

  always @(negedge clk) begin
    if (mon_en) chk("tv_align", tri_valid, prev_rd);
    prev_rd = mem_rd_en;
    if (mem_rd_en) begin
      addr_q.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
  end

  task automatic set_tab(input int i, input logic h, input logic [31:0] t);
    tab_h[i] = h;
    tab_t[i] = t;
  endtask

  task automatic start_job(input logic [15:0] base, input logic [15:0] cnt);
    @(negedge clk);
    addr_q.delete();
    rd_cyc.delete();
    cur_base  = base;
    tri_base  = base;
    tri_count = cnt;
    ray_valid = 1'b1;
    chk("accept_rdy", ray_ready, 1);
    @(posedge clk);
    #1 ray_valid = 1'b0;
  endtask

  // Runs a job; lat = clock edges from handshake cycle to first out_valid.
  task automatic run_job(input logic [15:0] base, input logic [15:0] cnt, output int lat);
    start_job(base, cnt);
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (lat >= 300) begin
        chk("timeout", 0, 1);
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic chk_res(input logic h, input logic [15:0] idx, input logic [31:0] t);
    chk("out_hit", out_hit, h);
    chk("out_idx", out_idx, idx);
    chk("out_t", out_t, t);
  endtask

  task automatic consume();
    @(posedge clk);
    @(negedge clk);
    chk("post_ov", out_valid, 0);
    chk("post_rdy", ray_ready, 1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; ray_valid = 1'b0; out_ready = 1'b1;
    tri_base = '0; tri_count = '0;
    for (int i = 0; i < 16; i++) set_tab(i, 1'b0, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", ray_ready, 0);
    chk("rst_rd", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_tv", tri_valid, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_hit", out_hit, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_t", out_t, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", ray_ready, 1);
    mon_en = 1'b1;

    // Basic 3-triangle job
    set_tab(0, 1, 32'h800); set_tab(1, 1, 32'h400); set_tab(2, 0, 32'h100);
    run_job(16'h0010, 16'd3, lat);
    chk("j1_lat", lat, 3 + HL + 2);
    chk_res(1, 16'd1, 32'h400);
    chk("j1_nrd", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      chk("j1_a0", addr_q[0], 16'h10);
      chk("j1_a1", addr_q[1], 16'h11);
      chk("j1_a2", addr_q[2], 16'h12);
      chk("j1_contig", rd_cyc[2] - rd_cyc[0], 2);
    end
    consume();

    // Empty job
    run_job(16'h0033, 16'd0, lat);
    chk("j0_lat", lat, 1);
    chk_res(0, 16'd0, 32'h0);
    chk("j0_nrd", addr_q.size(), 0);
    consume();

    // Tie and non-positive distances
    set_tab(0, 1, 32'h200); set_tab(1, 1, 32'h200);
    set_tab(2, 1, 32'hFFFFFC00); set_tab(3, 1, 32'h0);
    run_job(16'h0040, 16'd4, lat);
    chk("j2_lat", lat, 4 + HL + 2);
    chk_res(1, 16'd0, 32'h200);
    consume();

    // Address wrap
    set_tab(0, 0, 32'h10); set_tab(1, 1, 32'h300); set_tab(2, 1, 32'h100);
    run_job(16'hFFFE, 16'd3, lat);
    chk("j3_lat", lat, 3 + HL + 2);
    chk_res(1, 16'd2, 32'h100);
    chk("j3_nrd", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      chk("j3_a0", addr_q[0], 16'hFFFE);
      chk("j3_a1", addr_q[1], 16'hFFFF);
      chk("j3_a2", addr_q[2], 16'h0000);
    end
    consume();

    // Back-pressure in DONE
    set_tab(0, 1, 32'h50); set_tab(1, 1, 32'h30);
    out_ready = 1'b0;
    run_job(16'h0020, 16'd2, lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ov", out_valid, 1);
      chk("hold_rdy", ray_ready, 0);
      chk_res(1, 16'd1, 32'h30);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    consume();

    // Reset mid-job, then a miss job while stale results drain out
    for (int i = 0; i < 16; i++) set_tab(i, 1, 32'h10);
    start_job(16'h0100, 16'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_rd", mem_rd_en, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rdy", ray_ready, 0);
    chk("mid_rst_rd", mem_rd_en, 0);
    chk("mid_rst_tv", tri_valid, 0);
    chk("mid_rst_ov", out_valid, 0);
    rst_n = 1'b1;
    set_tab(0, 0, 32'h5);
    run_job(16'h0200, 16'd1, lat);
    chk("j5_lat", lat, 1 + HL + 2);
    chk_res(0, 16'd0, 32'h0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
